// File: rtl/packet_router.sv
// Header-parsing router that steers payload words to three output-port RAM buffers.
// Optional ROUTER_STATS_EN adds saturating packet and drop counters.
module packet_router #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] output1,
  output logic [DATA_W-1:0] output2,
  output logic [DATA_W-1:0] output3,
  output logic              out_ram_wr1,
  output logic              out_ram_wr2,
  output logic              out_ram_wr3,
  output logic              busy,
`ifdef ROUTER_STATS_EN
  output logic [15:0]       pkt_cnt1,
  output logic [15:0]       pkt_cnt2,
  output logic [15:0]       pkt_cnt3,
  output logic [15:0]       drop_cnt,
`endif
  output logic              drop_pulse
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [FILL_W-1:0] DEPTH_L   = FILL_W'(DEPTH);

  logic [1:0]              state_q, state_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [1:0]              port_q, port_d;
  logic [3:1][FILL_W-1:0]  fill_q, fill_d;
  logic [3:1]              wr_q, wr_d;
  logic                    drop_q, drop_d;
  logic [DATA_W-1:0]       dat_q;
  logic [3:1][DATA_W-1:0]  out_q;

  logic                    accept;
  logic [1:0]              hdr_dest;
  logic [LEN_W-1:0]        hdr_len;
  logic [FILL_W-1:0]       fill_sel;
  logic [FILL_W-1:0]       fill_sum;
  logic                    reject;

  assign in_ready = !reset;
  assign accept   = in_valid && in_ready;
  assign hdr_dest = in_data[DATA_W-1:DATA_W-2];
  assign hdr_len  = in_data[LEN_W-1:0];

  always_comb begin
    fill_sel = '0;
    case (hdr_dest)
      2'd1:    fill_sel = fill_q[1];
      2'd2:    fill_sel = fill_q[2];
      2'd3:    fill_sel = fill_q[3];
      default: fill_sel = '0;
    endcase
  end

  // Sum is wide enough to hold a full port plus any header length without wrapping.
  assign fill_sum = fill_sel + FILL_W'(hdr_len);
  assign reject   = (hdr_dest == 2'd0) || (hdr_len > MAX_LEN_L) || (fill_sum > DEPTH_L);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    port_d  = port_q;
    fill_d  = fill_q;
    wr_d    = '0;
    drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (reject) begin
            drop_d = 1'b1;
            if (hdr_len != '0) begin
              state_d = ST_DROP;
              rem_d   = hdr_len;
            end
          end else if (hdr_len != '0) begin
            state_d          = ST_FWD;
            rem_d            = hdr_len;
            port_d           = hdr_dest;
            fill_d[hdr_dest] = fill_sum;
          end
        end
      end
      ST_FWD: begin
        if (accept) begin
          wr_d[port_q] = 1'b1;
          rem_d        = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe leads data by one cycle: the buffer registers the strobe before writing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      port_q  <= '0;
      fill_q  <= '0;
      wr_q    <= '0;
      drop_q  <= 1'b0;
      dat_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      port_q  <= port_d;
      fill_q  <= fill_d;
      wr_q    <= wr_d;
      drop_q  <= drop_d;
      if (|wr_d) dat_q <= in_data;
      if (wr_q[1]) out_q[1] <= dat_q;
      if (wr_q[2]) out_q[2] <= dat_q;
      if (wr_q[3]) out_q[3] <= dat_q;
    end
  end

  assign output1     = out_q[1];
  assign output2     = out_q[2];
  assign output3     = out_q[3];
  assign out_ram_wr1 = wr_q[1];
  assign out_ram_wr2 = wr_q[2];
  assign out_ram_wr3 = wr_q[3];
  assign busy        = (state_q != ST_IDLE);
  assign drop_pulse  = drop_q;

`ifdef ROUTER_STATS_EN
  logic [3:1][15:0] pkt_q;
  logic [15:0]      drop_cnt_q;
  logic             pkt_done;

  assign pkt_done = (state_q == ST_FWD) && accept && (rem_q == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pkt_done && (pkt_q[port_q] != 16'hFFFF)) pkt_q[port_q] <= pkt_q[port_q] + 16'd1;
      if (drop_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt1 = pkt_q[1];
  assign pkt_cnt2 = pkt_q[2];
  assign pkt_cnt3 = pkt_q[3];
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_packet_router.sv
// Scoreboard bench for packet_router: a packet-level model queues expected strobes,
// data and drop pulses; a negedge monitor pops and compares them.
module tb_packet_router;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] output1, output2, output3;
  logic        out_ram_wr1, out_ram_wr2, out_ram_wr3;
  logic        busy, drop_pulse;
`ifdef ROUTER_STATS_EN
  logic [15:0] pkt_cnt1, pkt_cnt2, pkt_cnt3, drop_cnt;
`endif

  packet_router dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .output1     (output1),
    .output2     (output2),
    .output3     (output3),
    .out_ram_wr1 (out_ram_wr1),
    .out_ram_wr2 (out_ram_wr2),
    .out_ram_wr3 (out_ram_wr3),
    .busy        (busy),
`ifdef ROUTER_STATS_EN
    .pkt_cnt1    (pkt_cnt1),
    .pkt_cnt2    (pkt_cnt2),
    .pkt_cnt3    (pkt_cnt3),
    .drop_cnt    (drop_cnt),
`endif
    .drop_pulse  (drop_pulse)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_prev = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= reset;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Packet-level reference model.
  typedef struct {
    int          port;
    logic [31:0] data;
    int          edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];
  int   m_state;  // 0 header expected, 1 forwarding, 2 discarding
  int   m_rem;
  int   m_port;
  int   m_fill[4];
  int   m_pkt[4];
  int   m_drops;

  task automatic model_clear();
    m_state = 0;
    m_rem   = 0;
    m_port  = 0;
    m_drops = 0;
    for (int i = 0; i < 4; i++) begin
      m_fill[i] = 0;
      m_pkt[i]  = 0;
    end
  endtask

  task automatic model_word(logic [31:0] w, int edge_n);
    int dest;
    int len;
    exp_t e;
    if (m_state == 0) begin
      dest = int'(w[31:30]);
      len  = int'(w[11:0]);
      if (dest == 0 || len > 1024 || m_fill[dest] + len > 4096) begin
        drop_q.push_back(edge_n);
        m_drops++;
        if (len != 0) begin
          m_state = 2;
          m_rem   = len;
        end
      end else if (len != 0) begin
        m_state      = 1;
        m_rem        = len;
        m_port       = dest;
        m_fill[dest] = m_fill[dest] + len;
      end
    end else begin
      if (m_state == 1) begin
        e.port   = m_port;
        e.data   = w;
        e.edge_n = edge_n;
        exp_q.push_back(e);
      end
      m_rem--;
      if (m_rem == 0) begin
        if (m_state == 1) m_pkt[m_port]++;
        m_state = 0;
      end
    end
  endtask

  // Monitor: strobe must appear on the cycle after acceptance, data one cycle later.
  logic [31:0] mo[1:3];
  logic        mw[1:3];
  logic [31:0] pend_data[1:3];
  bit          pend_v[1:3];
  exp_t        mon_e;
  int          mon_d;

  assign mo[1] = output1;
  assign mo[2] = output2;
  assign mo[3] = output3;
  assign mw[1] = out_ram_wr1;
  assign mw[2] = out_ram_wr2;
  assign mw[3] = out_ram_wr3;

  always @(negedge clk) begin
    if (rst_prev) begin
      for (int i = 1; i <= 3; i++) begin
        check("reset_output", mo[i], 32'd0);
        check("reset_strobe", mw[i], 1'b0);
        pend_v[i] = 1'b0;
      end
      check("reset_drop_pulse", drop_pulse, 1'b0);
      check("reset_busy", busy, 1'b0);
    end else begin
      for (int i = 1; i <= 3; i++) begin
        if (pend_v[i]) begin
          check("output_data", mo[i], pend_data[i]);
          pend_v[i] = 1'b0;
        end
      end
      if (32'(mw[1]) + 32'(mw[2]) + 32'(mw[3]) > 1) check("strobe_onehot", 1, 0);
      for (int i = 1; i <= 3; i++) begin
        if (mw[i]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe_port", i, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("strobe_port", i, mon_e.port);
            check("strobe_cycle", cyc, mon_e.edge_n);
            pend_v[i]    = 1'b1;
            pend_data[i] = mon_e.data;
          end
        end
      end
      if (drop_pulse) begin
        if (drop_q.size() == 0) begin
          check("unexpected_drop_pulse", 1, 0);
        end else begin
          mon_d = drop_q.pop_front();
          check("drop_pulse_cycle", cyc, mon_d);
        end
      end
    end
  end

  // Stimulus drivers: inputs change 1 time unit after the active edge.
  task automatic drive(bit v, logic [31:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    if (v && !reset) model_word(d, cyc + 1);
  endtask

  task automatic send(logic [31:0] d);
    drive(1'b1, d);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, $urandom);
  endtask

  function automatic logic [31:0] hdr(int dest, int len);
    logic [17:0] mid;
    logic [31:0] d;
    logic [31:0] l;
    mid = 18'($urandom);
    d   = dest;
    l   = len;
    return {d[1:0], mid, l[11:0]};
  endfunction

  task automatic send_pkt(int dest, int len, int gap_pct);
    send(hdr(dest, len));
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
      send($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_in_reset", in_ready, 1'b0);
    reset = 1'b0;
    model_clear();
    #1;
    check("in_ready_after_reset", in_ready, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_in_reset", in_ready, 1'b0);
    reset = 1'b0;

    // Contiguous 3-word packet to port 1.
    send_pkt(1, 3, 0);
    idle(3);
    check("busy_idle_after_pkt", busy, 1'b0);

    // Port-0 drop, then the next word is a header.
    send_pkt(0, 2, 0);
    send_pkt(1, 1, 0);
    idle(2);

    // Port 3 with a 2-cycle gap after word 2.
    send(hdr(3, 4));
    send(32'hA000_0001);
    send(32'hA000_0002);
    idle(2);
    send(32'hA000_0003);
    send(32'hA000_0004);
    idle(3);

    // Fill port 2 to exactly DEPTH, then overflow and a zero-length header.
    do_reset();
    repeat (4) send_pkt(2, 1024, 0);
    send_pkt(2, 1, 0);
    send(hdr(2, 0));
    idle(1);
    check("busy_after_len0", busy, 1'b0);
    send_pkt(3, 2, 0);
    send_pkt(1, 1025, 0);
    idle(3);

    // Reset in the middle of a forwarded packet.
    do_reset();
    send(hdr(1, 8));
    send($urandom);
    send($urandom);
    send($urandom);
    idle(1);
    @(negedge clk);
    check("busy_mid_packet", busy, 1'b1);
    do_reset();
    send_pkt(1, 1, 0);
    idle(3);

`ifdef ROUTER_STATS_EN
    do_reset();
    repeat (3) send_pkt(1, 2, 0);
    send_pkt(0, 0, 0);
    send_pkt(3, 1025, 0);
    idle(3);
    check("pkt_cnt1", pkt_cnt1, 16'(m_pkt[1]));
    check("pkt_cnt2", pkt_cnt2, 16'd0);
    check("pkt_cnt3", pkt_cnt3, 16'd0);
    check("drop_cnt", drop_cnt, 16'(m_drops));
`endif

    // Randomised traffic with gaps, oversize and port-0 packets.
    do_reset();
    for (int p = 0; p < 120; p++) begin
      int dest;
      int len;
      dest = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) len = $urandom_range(1000, 1100);
      else len = $urandom_range(0, 15);
      send_pkt(dest, len, 25);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(5);

    check("strobes_outstanding", exp_q.size(), 0);
    check("drops_outstanding", drop_q.size(), 0);
    check("busy_at_end", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
